// File: rtl/bus_xfer_arbiter_if.sv
// Requester-side bus bundle of the transfer arbiter.
// Carries the per-requester commands and the one-hot register enables.
interface bus_xfer_arbiter_if #(
    parameter int NUM_REGS = 8,
    parameter int NUM_REQ  = 4
);
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [NUM_REQ-1:0]      Req;
    logic [NUM_REQ*IDXW-1:0] ReqSrc;
    logic [NUM_REQ*IDXW-1:0] ReqDst;
    logic [NUM_REGS-1:0]     RegOut;
    logic [NUM_REGS-1:0]     RegIn;
    logic [NUM_REQ-1:0]      Done;
    logic                    Err;
    logic                    Busy;

    modport master (
        output Req, ReqSrc, ReqDst,
        input  RegOut, RegIn, Done, Err, Busy
    );

    modport slave (
        input  Req, ReqSrc, ReqDst,
        output RegOut, RegIn, Done, Err, Busy
    );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// Round-robin sequencer for register-to-register moves on the shared bus.
// One driver per cycle, settle cycle before capture, idle turnaround after.
module bus_xfer_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int NUM_REQ  = 4
) (
    input logic               Clk,
    input logic               Rst,
    bus_xfer_arbiter_if.slave bus
);
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_XFER,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic [IDXW-1:0]     r_src;
    logic [IDXW-1:0]     r_dst;
    logic                r_bad;
    logic [NUM_REGS-1:0] r_regout;
    logic [NUM_REGS-1:0] r_regin;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_err;
    logic                r_busy;

    state_t              w_state_nx;
    logic [PW-1:0]       w_ptr_nx;
    logic [PW-1:0]       w_win_nx;
    logic [IDXW-1:0]     w_src_nx;
    logic [IDXW-1:0]     w_dst_nx;
    logic                w_bad_nx;
    logic [NUM_REGS-1:0] w_regout_nx;
    logic [NUM_REGS-1:0] w_regin_nx;
    logic [NUM_REQ-1:0]  w_done_nx;
    logic                w_err_nx;

    logic                w_found;
    logic [PW-1:0]       w_pick;
    int                  w_idx;
    logic [IDXW-1:0]     w_src;
    logic [IDXW-1:0]     w_dst;
    logic                w_bad;

    function automatic logic [NUM_REGS-1:0] f_reg_hot(
        input logic [IDXW-1:0] idx
    );
        f_reg_hot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) f_reg_hot[i] = 1'b1;
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] f_req_hot(
        input logic [PW-1:0] idx
    );
        f_req_hot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(idx) == i) f_req_hot[i] = 1'b1;
        end
    endfunction

    // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && bus.Req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_src = bus.ReqSrc[int'(w_pick)*IDXW +: IDXW];
        w_dst = bus.ReqDst[int'(w_pick)*IDXW +: IDXW];
        w_bad = (w_src == w_dst)
             || (int'(w_src) >= NUM_REGS)
             || (int'(w_dst) >= NUM_REGS);
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_win_nx    = r_win;
        w_src_nx    = r_src;
        w_dst_nx    = r_dst;
        w_bad_nx    = r_bad;
        w_regout_nx = '0;
        w_regin_nx  = '0;
        w_done_nx   = '0;
        w_err_nx    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nx = w_pick;
                    w_src_nx = w_src;
                    w_dst_nx = w_dst;
                    w_bad_nx = w_bad;
                    if (w_bad) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = f_req_hot(w_pick);
                        w_err_nx   = 1'b1;
                    end else begin
                        w_state_nx  = S_DRIVE;
                        w_regout_nx = f_reg_hot(w_src);
                    end
                end
            end
            S_DRIVE: begin
                w_state_nx  = S_XFER;
                w_regout_nx = f_reg_hot(r_src);
                w_regin_nx  = f_reg_hot(r_dst);
            end
            S_XFER: begin
                w_state_nx = S_DONE;
                w_done_nx  = f_req_hot(r_win);
                w_err_nx   = r_bad;
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                if (int'(r_win) == NUM_REQ - 1) begin
                    w_ptr_nx = '0;
                end else begin
                    w_ptr_nx = r_win + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_bad    <= 1'b0;
            r_regout <= '0;
            r_regin  <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_win    <= w_win_nx;
            r_src    <= w_src_nx;
            r_dst    <= w_dst_nx;
            r_bad    <= w_bad_nx;
            r_regout <= w_regout_nx;
            r_regin  <= w_regin_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_busy   <= (w_state_nx != S_IDLE);
        end
    end

    assign bus.RegOut = r_regout;
    assign bus.RegIn  = r_regin;
    assign bus.Done   = r_done;
    assign bus.Err    = r_err;
    assign bus.Busy   = r_busy;
endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Directed and randomized bench for bus_xfer_arbiter with a register-bank
// model on the shared bus.
module tb_bus_xfer_arbiter;
    localparam int NREQ = 4;
    localparam int IDX  = 3;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    bus_xfer_arbiter_if #(.NUM_REGS(8), .NUM_REQ(NREQ)) ifc ();
    bus_xfer_arbiter_if #(.NUM_REGS(6), .NUM_REQ(NREQ)) ifc6 ();

    bus_xfer_arbiter #(.NUM_REGS(8), .NUM_REQ(NREQ)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc.slave)
    );

    bus_xfer_arbiter #(.NUM_REGS(6), .NUM_REQ(NREQ)) u_dut6 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc6.slave)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mreg [8] = '{16'h1000, 16'h1111, 16'hA5C3, 16'h3333,
                              16'h4444, 16'h5555, 16'h6666, 16'h7777};
    logic [15:0] bus_val;
    logic [7:0]  prev_in = '0;

    always_comb begin
        bus_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.RegOut[i]) bus_val = bus_val | mreg[i];
        end
    end

    always @(posedge Clk) begin
        for (int i = 0; i < 8; i++) begin
            if (ifc.RegIn[i]) mreg[i] <= bus_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input int s, input int d);
        ifc.ReqSrc[r*IDX +: IDX] = IDX'(s);
        ifc.ReqDst[r*IDX +: IDX] = IDX'(d);
    endtask

    // Bus invariants, checked every cycle away from the active edge.
    always @(negedge Clk) begin
        chk("onehot_out", 32'($countones(ifc.RegOut) <= 1), 32'd1);
        chk("onehot_in", 32'($countones(ifc.RegIn) <= 1), 32'd1);
        chk("in_needs_out",
            32'((ifc.RegIn != 0) && (ifc.RegOut == 0)), 32'd0);
        chk("turnaround", 32'((prev_in != 0) && (ifc.RegOut != 0)), 32'd0);
        chk("done_no_out", 32'((ifc.Done != 0) && (ifc.RegOut != 0)), 32'd0);
        chk("onehot_done", 32'($countones(ifc.Done) <= 1), 32'd1);
        chk("err_with_done", 32'(ifc.Err && (ifc.Done == 0)), 32'd0);
        prev_in = ifc.RegIn;
    end

    logic [15:0] exp_reg [8];
    int          src_q [NREQ];
    int          dst_q [NREQ];
    int          waits [NREQ];
    int          hold  [NREQ];

    initial begin
        ifc.Req = '0;
        ifc.ReqSrc = '0;
        ifc.ReqDst = '0;
        ifc6.Req = '0;
        ifc6.ReqSrc = '0;
        ifc6.ReqDst = '0;
        step();
        step();
        chk("rst_regout", 32'(ifc.RegOut), 32'h0);
        chk("rst_regin", 32'(ifc.RegIn), 32'h0);
        chk("rst_done", 32'(ifc.Done), 32'h0);
        chk("rst_err", 32'(ifc.Err), 32'h0);
        chk("rst_busy", 32'(ifc.Busy), 32'h0);
        Rst = 1'b0;

        // Single transfer reg2 -> reg5 by requester 0.
        set_cmd(0, 2, 5);
        ifc.Req = 4'b0001;
        step();
        chk("t1_c1_out", 32'(ifc.RegOut), 32'h04);
        chk("t1_c1_in", 32'(ifc.RegIn), 32'h00);
        chk("t1_c1_busy", 32'(ifc.Busy), 32'h1);
        ifc.Req = '0;
        step();
        chk("t1_c2_out", 32'(ifc.RegOut), 32'h04);
        chk("t1_c2_in", 32'(ifc.RegIn), 32'h20);
        step();
        chk("t1_c3_done", 32'(ifc.Done), 32'h1);
        chk("t1_c3_err", 32'(ifc.Err), 32'h0);
        chk("t1_c3_out", 32'(ifc.RegOut), 32'h0);
        chk("t1_c3_in", 32'(ifc.RegIn), 32'h0);
        chk("t1_reg5", 32'(mreg[5]), 32'hA5C3);
        step();
        chk("t1_c4_busy", 32'(ifc.Busy), 32'h0);
        chk("t1_c4_done", 32'(ifc.Done), 32'h0);

        // Requester 1 withdraws its request during DRIVE.
        set_cmd(1, 1, 6);
        ifc.Req = 4'b0010;
        step();
        chk("wd_c1_out", 32'(ifc.RegOut), 32'h02);
        ifc.Req = '0;
        step();
        chk("wd_c2_in", 32'(ifc.RegIn), 32'h40);
        step();
        chk("wd_c3_done", 32'(ifc.Done), 32'h2);
        chk("wd_reg6", 32'(mreg[6]), 32'h1111);
        step();

        // Reset wins over a simultaneous request; then round-robin.
        for (int i = 0; i < NREQ; i++) set_cmd(i, i, i + 4);
        Rst = 1'b1;
        ifc.Req = 4'b1111;
        step();
        chk("rr_rst_busy", 32'(ifc.Busy), 32'h0);
        chk("rr_rst_out", 32'(ifc.RegOut), 32'h0);
        Rst = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c % 4 == 3) begin
                chk($sformatf("rr_c%0d", c), 32'(ifc.Done),
                    32'(1 << ((c / 4) % 4)));
            end else begin
                chk($sformatf("rr_c%0d", c), 32'(ifc.Done), 32'h0);
            end
        end
        ifc.Req = '0;
        step();
        step();

        // Illegal: src == dst.
        set_cmd(2, 3, 3);
        ifc.Req = 4'b0100;
        step();
        chk("ill_done", 32'(ifc.Done), 32'h4);
        chk("ill_err", 32'(ifc.Err), 32'h1);
        chk("ill_out", 32'(ifc.RegOut), 32'h0);
        chk("ill_in", 32'(ifc.RegIn), 32'h0);
        ifc.Req = '0;
        step();
        chk("ill_after_done", 32'(ifc.Done), 32'h0);
        chk("ill_after_err", 32'(ifc.Err), 32'h0);
        chk("ill_after_busy", 32'(ifc.Busy), 32'h0);

        // Six-register instance: out-of-range indices and top legal index.
        ifc6.ReqSrc[0 +: IDX] = 3'd7;
        ifc6.ReqDst[0 +: IDX] = 3'd1;
        ifc6.Req = 4'b0001;
        step();
        chk("r6_src7_done", 32'(ifc6.Done), 32'h1);
        chk("r6_src7_err", 32'(ifc6.Err), 32'h1);
        chk("r6_src7_out", 32'(ifc6.RegOut), 32'h0);
        ifc6.Req = '0;
        step();
        ifc6.ReqSrc[0 +: IDX] = 3'd0;
        ifc6.ReqDst[0 +: IDX] = 3'd6;
        ifc6.Req = 4'b0001;
        step();
        chk("r6_dst6_err", 32'(ifc6.Err), 32'h1);
        chk("r6_dst6_in", 32'(ifc6.RegIn), 32'h0);
        ifc6.Req = '0;
        step();
        ifc6.ReqSrc[0 +: IDX] = 3'd5;
        ifc6.ReqDst[0 +: IDX] = 3'd0;
        ifc6.Req = 4'b0001;
        step();
        chk("r6_ok_out", 32'(ifc6.RegOut), 32'h20);
        ifc6.Req = '0;
        step();
        chk("r6_ok_in", 32'(ifc6.RegIn), 32'h01);
        step();
        chk("r6_ok_done", 32'(ifc6.Done), 32'h1);
        chk("r6_ok_err", 32'(ifc6.Err), 32'h0);
        step();

        // Reset during XFER: no Done, pointer back to requester 0.
        set_cmd(3, 1, 2);
        ifc.Req = 4'b1000;
        step();
        step();
        chk("rx_xfer_in", 32'(ifc.RegIn), 32'h04);
        Rst = 1'b1;
        step();
        chk("rx_out", 32'(ifc.RegOut), 32'h0);
        chk("rx_in", 32'(ifc.RegIn), 32'h0);
        chk("rx_done", 32'(ifc.Done), 32'h0);
        chk("rx_busy", 32'(ifc.Busy), 32'h0);
        Rst = 1'b0;
        set_cmd(0, 0, 4);
        ifc.Req = 4'b1001;
        step();
        step();
        step();
        chk("rx_ptr0", 32'(ifc.Done), 32'h1);
        ifc.Req = '0;
        step();
        step();

        // Random stress with requesters that hold Req until Done.
        for (int i = 0; i < 8; i++) exp_reg[i] = mreg[i];
        for (int i = 0; i < NREQ; i++) begin
            waits[i] = 0;
            hold[i]  = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (ifc.Req[i]) begin
                    if (ifc.Done[i]) begin
                        chk("st_err", 32'(ifc.Err),
                            32'(src_q[i] == dst_q[i]));
                        chk("st_starve", 32'(waits[i] <= NREQ - 1), 32'd1);
                        if (src_q[i] != dst_q[i]) begin
                            exp_reg[dst_q[i]] = exp_reg[src_q[i]];
                            chk("st_data", 32'(mreg[dst_q[i]]),
                                32'(exp_reg[dst_q[i]]));
                        end
                        ifc.Req[i] = 1'b0;
                        hold[i] = int'($urandom_range(0, 3));
                    end else if (ifc.Done != 0) begin
                        waits[i]++;
                    end
                end else if (hold[i] > 0) begin
                    hold[i]--;
                end else if ($urandom_range(0, 1) == 1) begin
                    src_q[i] = int'($urandom_range(0, 7));
                    dst_q[i] = ($urandom_range(0, 7) == 0) ? src_q[i]
                             : int'($urandom_range(0, 7));
                    set_cmd(i, src_q[i], dst_q[i]);
                    waits[i] = 0;
                    ifc.Req[i] = 1'b1;
                end
            end
        end
        ifc.Req = '0;
        repeat (6) step();
        chk("end_busy", 32'(ifc.Busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
